// File: rtl/siso_shift_scheduler_pkg.sv
// Shared types and defaults for the SISO shift-register scheduler.
// The state encoding is fixed so that it reads the same in waveforms and in the sub-blocks.
package siso_shift_scheduler_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/siso_shift_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer value after that grant.
// ptr names the requester that wins when both are asking.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       ptr_next
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      // Win when the other side is quiet, or when the pointer favours this side.
      assign grant[gi] = en & req[gi] & (~req[1-gi] | (ptr == 1'(gi)));
    end
  endgenerate

  assign ptr_next = (|grant) ? ~grant[1] : ptr;

endmodule

// File: rtl/siso_shift_scheduler.sv
// Sequencer for a shared external SISO shift register: grants one of two requesters,
// clears the register, streams the word through it LSB-first and reassembles the far-end bits.
module siso_shift_scheduler
  import siso_shift_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(WIDTH + DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             resp_match,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             sr_clr,
  output logic             busy
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH + DEPTH - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic [WIDTH-1:0] rx_reg, rx_next;
  logic [WIDTH-1:0] tx_bits;
  logic             id_reg, id_next;
  logic             rr_reg, rr_next;
  logic             arb_en, arb_ptr_next;
  logic [1:0]       grant;
  logic             ser_out_reg, ser_out_next;
  logic             sr_clr_reg, sr_clr_next;
  logic             resp_valid_reg, resp_valid_next;
  logic [WIDTH-1:0] resp_data_reg, resp_data_next;
  logic             resp_id_reg, resp_id_next;
  logic             resp_match_reg, resp_match_next;

  // Gating with rst keeps req_ready low while reset is held, not just after the next edge.
  assign arb_en = (state_reg == IDLE) && rst;

  rr_arbiter2 u_arb (
    .req      (req_valid),
    .ptr      (rr_reg),
    .en       (arb_en),
    .grant    (grant),
    .ptr_next (arb_ptr_next)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rx
      // Bit gi returns from the far end DEPTH cycles after it was launched.
      localparam logic [CW-1:0] SAMPLE_AT = CW'(DEPTH + gi);
      assign rx_next[gi] = (state_reg == SHIFT && cnt_reg == SAMPLE_AT) ? ser_in : rx_reg[gi];
    end
  endgenerate

  // Shifting past the top of the word yields the trailing zeros that flush the line.
  assign tx_bits = word_reg >> cnt_next;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    word_next       = word_reg;
    id_next         = id_reg;
    rr_next         = rr_reg;
    resp_valid_next = resp_valid_reg;
    resp_data_next  = resp_data_reg;
    resp_id_next    = resp_id_reg;
    resp_match_next = resp_match_reg;

    unique case (state_reg)
      IDLE: begin
        if (|grant) begin
          word_next  = grant[1] ? req_data1 : req_data0;
          id_next    = grant[1];
          rr_next    = arb_ptr_next;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        cnt_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt_reg == LAST) begin
          cnt_next        = '0;
          state_next      = DONE;
          resp_valid_next = 1'b1;
          resp_data_next  = rx_next;
          resp_id_next    = id_reg;
          resp_match_next = (rx_next == word_reg);
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    sr_clr_next  = (state_next == CLEAR);
    ser_out_next = (state_next == SHIFT) & tx_bits[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      word_reg       <= '0;
      rx_reg         <= '0;
      id_reg         <= 1'b0;
      rr_reg         <= 1'b0;
      ser_out_reg    <= 1'b0;
      sr_clr_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_id_reg    <= 1'b0;
      resp_match_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      word_reg       <= word_next;
      rx_reg         <= rx_next;
      id_reg         <= id_next;
      rr_reg         <= rr_next;
      ser_out_reg    <= ser_out_next;
      sr_clr_reg     <= sr_clr_next;
      resp_valid_reg <= resp_valid_next;
      resp_data_reg  <= resp_data_next;
      resp_id_reg    <= resp_id_next;
      resp_match_reg <= resp_match_next;
    end
  end

  assign req_ready  = grant;
  assign ser_out    = ser_out_reg;
  assign sr_clr     = sr_clr_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_id    = resp_id_reg;
  assign resp_match = resp_match_reg;
  assign busy       = (state_reg != IDLE);

endmodule
